// File: rtl/cacheline_arb_types.sv
// rtl/cacheline_arb_types.sv - shared state/op encodings and line geometry for the cacheline arbiter
package cacheline_arb_types;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_I,
        ARB_D
    } state_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } op_t;

    localparam int LINE_BYTES  = 32;
    localparam int OFFSET_BITS = $clog2(LINE_BYTES);

endpackage

// File: rtl/cacheline_arb_select.sv
// rtl/cacheline_arb_select.sv - I/D grant selection; CACHELINE_ARB_RR_EN enables round-robin on contention
module cacheline_arb_select (
    input  logic i_req,
    input  logic d_req,
    input  logic rr_ptr,
    output logic grant_i,
    output logic grant_d
);

`ifdef CACHELINE_ARB_RR_EN
    // rr_ptr == 0 favours D, rr_ptr == 1 favours I
    always_comb begin
        grant_d = d_req && (!i_req || !rr_ptr);
        grant_i = i_req && (!d_req || rr_ptr);
    end
`else
    logic unused_rr_ptr;
    assign unused_rr_ptr = rr_ptr;

    always_comb begin
        grant_d = d_req;
        grant_i = i_req && !d_req;
    end
`endif

endmodule

// File: rtl/cacheline_arbiter.sv
// rtl/cacheline_arbiter.sv - shares one pmem cacheline port between I-cache and D-cache; CACHELINE_ARB_RR_EN selects round-robin contention
module cacheline_arbiter
    import cacheline_arb_types::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = LINE_BYTES * 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    localparam int OFF = (LINE_WIDTH == LINE_BYTES * 8) ? OFFSET_BITS : $clog2(LINE_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'((64'd1 << OFF) - 64'd1);

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [LINE_WIDTH-1:0]   wdata_q;
    logic                    rr_ptr;
    logic                    i_req;
    logic                    d_req;
    logic                    grant_i;
    logic                    grant_d;
    op_t                     d_op;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

    // a simultaneous read+write from the D-cache is a writeback
    always_comb begin
        d_op = d_write ? OP_WRITE : OP_READ;
    end

    cacheline_arb_select u_select (
        .i_req   (i_req),
        .d_req   (d_req),
        .rr_ptr  (rr_ptr),
        .grant_i (grant_i),
        .grant_d (grant_d)
    );

`ifdef CACHELINE_ARB_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (state == ARB_IDLE && i_req && d_req) begin
            rr_ptr <= ~rr_ptr;
        end
    end
`else
    assign rr_ptr = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ARB_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (grant_d) begin
                        state      <= ARB_D;
                        addr_q     <= d_address & ALIGN_MASK;
                        wdata_q    <= d_wdata;
                        pmem_read  <= (d_op == OP_READ);
                        pmem_write <= (d_op == OP_WRITE);
                    end else if (grant_i) begin
                        state      <= ARB_I;
                        addr_q     <= i_address & ALIGN_MASK;
                        wdata_q    <= '0;
                        pmem_read  <= 1'b1;
                        pmem_write <= 1'b0;
                    end
                end
                ARB_I, ARB_D: begin
                    if (pmem_resp) begin
                        state      <= ARB_IDLE;
                        pmem_read  <= 1'b0;
                        pmem_write <= 1'b0;
                    end
                end
                default: begin
                    state      <= ARB_IDLE;
                    pmem_read  <= 1'b0;
                    pmem_write <= 1'b0;
                end
            endcase
        end
    end

    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    // completion is steered combinationally so resp lands in the pmem_resp cycle
    assign i_resp  = (state == ARB_I) && pmem_resp;
    assign d_resp  = (state == ARB_D) && pmem_resp;
    assign i_rdata = (state == ARB_I) ? pmem_rdata : '0;
    assign d_rdata = (state == ARB_D) ? pmem_rdata : '0;

endmodule

// File: tb/tb_cacheline_arbiter.sv
// tb/tb_cacheline_arbiter.sv - table-driven and scoreboard bench for cacheline_arbiter
module tb_cacheline_arbiter;

    logic         clk;
    logic         rst;
    logic         i_read;
    logic [31:0]  i_address;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic         d_read;
    logic         d_write;
    logic [31:0]  d_address;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic         side_d;
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
    } exp_t;

    typedef struct {
        logic         i_rd;
        logic         d_rd;
        logic         d_wr;
        logic [31:0]  i_addr;
        logic [31:0]  d_addr;
        logic [255:0] wdata;
        logic [255:0] rdata;
        int           lat;
        logic         exp_d;
        logic         exp_wr;
        logic [31:0]  exp_addr;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[6];

    cacheline_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .i_read       (i_read),
        .i_address    (i_address),
        .i_rdata      (i_rdata),
        .i_resp       (i_resp),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_address    (d_address),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_resp       (d_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_bit(input string name, input logic act, input logic req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0b, required %0b", name, act, req);
    endtask

    task automatic chk_addr(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %08h, required %08h", name, act, req);
    endtask

    task automatic chk_line(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %064h, required %064h", name, act, req);
    endtask

    task automatic chk_int(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    task automatic push_exp(input logic side_d, input logic wr, input logic [31:0] addr,
                            input logic [255:0] wdata);
        exp_t e;
        e.side_d = side_d;
        e.wr     = wr;
        e.addr   = addr;
        e.wdata  = wdata;
        sb.push_back(e);
    endtask

    task automatic wait_grant(input int exp_cycles);
        int  n    = 0;
        bit  seen = 1'b0;
        for (int k = 1; k <= 8 && !seen; k++) begin
            @(negedge clk);
            #1;
            if (pmem_read || pmem_write) begin
                seen = 1'b1;
                n    = k;
            end
        end
        chk_int("grant_latency", n, exp_cycles);
    endtask

    task automatic check_front();
        exp_t e;
        if (sb.size() == 0) begin
            chk_int("sb_nonempty_at_grant", 0, 1);
            return;
        end
        e = sb[0];
        chk_bit("pmem_read", pmem_read, !e.wr);
        chk_bit("pmem_write", pmem_write, e.wr);
        chk_addr("pmem_address", pmem_address, e.addr);
        if (e.wr) chk_line("pmem_wdata", pmem_wdata, e.wdata);
    endtask

    task automatic respond(input logic [255:0] data, input int lat);
        exp_t e;
        if (sb.size() == 0) begin
            chk_int("sb_nonempty_at_resp", 0, 1);
            return;
        end
        for (int k = 1; k < lat; k++) begin
            @(negedge clk);
            #1;
            chk_addr("addr_hold", pmem_address, sb[0].addr);
            chk_bit("op_hold", pmem_write, sb[0].wr);
            chk_bit("strobe_hold", pmem_read | pmem_write, 1'b1);
            chk_bit("early_resp", i_resp | d_resp, 1'b0);
        end
        @(negedge clk);
        pmem_resp  = 1'b1;
        pmem_rdata = data;
        #1;
        e = sb.pop_front();
        chk_bit("i_resp", i_resp, !e.side_d);
        chk_bit("d_resp", d_resp, e.side_d);
        if (e.side_d) chk_line("d_rdata", d_rdata, data);
        else          chk_line("i_rdata", i_rdata, data);
        chk_bit("strobe_in_resp", e.wr ? pmem_write : pmem_read, 1'b1);
        chk_bit("no_dual_strobe", pmem_read & pmem_write, 1'b0);
    endtask

    task automatic release_req(input logic drop_i, input logic drop_d);
        @(negedge clk);
        pmem_resp = 1'b0;
        if (drop_i) i_read = 1'b0;
        if (drop_d) begin
            d_read  = 1'b0;
            d_write = 1'b0;
        end
        #1;
        chk_bit("idle_strobes", pmem_read | pmem_write, 1'b0);
        chk_bit("idle_resp", i_resp | d_resp, 1'b0);
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        i_read    = v.i_rd;
        d_read    = v.d_rd;
        d_write   = v.d_wr;
        i_address = v.i_addr;
        d_address = v.d_addr;
        d_wdata   = v.wdata;
        push_exp(v.exp_d, v.exp_wr, v.exp_addr, v.wdata);
        wait_grant(1);
        check_front();
        respond(v.rdata, v.lat);
        release_req(1'b1, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic first_d;
        vec_t v;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0064, 32'h0, 256'h0, {32{8'hAA}},
                    3, 1'b0, 1'b0, 32'h0000_0060};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h0, 32'h8000_001F, {4{64'h1234_5678_9ABC_DEF0}},
                    256'h0, 2, 1'b1, 1'b1, 32'h8000_0000};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_1234, 256'h0, {8{32'hCAFE_F00D}},
                    1, 1'b1, 1'b0, 32'h0000_1220};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_0047, {16{16'h5A5A}}, {8{32'h1111_2222}},
                    2, 1'b1, 1'b1, 32'h0000_0040};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, 256'h0, {4{64'h0123_4567_89AB_CDEF}},
                    4, 1'b0, 1'b0, 32'hFFFF_FFE0};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_003F, {8{32'h0F0F_0F0F}}, 256'h0,
                    1, 1'b1, 1'b1, 32'h0000_0020};

        rst        = 1'b1;
        i_read     = 1'b0;
        i_address  = '0;
        d_read     = 1'b0;
        d_write    = 1'b0;
        d_address  = '0;
        d_wdata    = '0;
        pmem_rdata = '0;
        pmem_resp  = 1'b0;
        #2;
        chk_bit("rst_pmem_read", pmem_read, 1'b0);
        chk_bit("rst_pmem_write", pmem_write, 1'b0);
        chk_addr("rst_pmem_address", pmem_address, 32'h0);
        chk_line("rst_pmem_wdata", pmem_wdata, 256'h0);
        chk_bit("rst_i_resp", i_resp, 1'b0);
        chk_bit("rst_d_resp", d_resp, 1'b0);
        chk_line("rst_i_rdata", i_rdata, 256'h0);
        chk_line("rst_d_rdata", d_rdata, 256'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int n = 0; n < 6; n++) run_vec(vecs[n]);

        // first contention: D wins in both builds
        @(negedge clk);
        i_read    = 1'b1;
        d_read    = 1'b1;
        i_address = 32'h0000_0100;
        d_address = 32'h0000_0200;
        push_exp(1'b1, 1'b0, 32'h0000_0200, 256'h0);
        push_exp(1'b0, 1'b0, 32'h0000_0100, 256'h0);
        wait_grant(1);
        check_front();
        respond({8{32'hD00D_0001}}, 2);
        release_req(1'b0, 1'b1);
        wait_grant(1);
        check_front();
        respond({8{32'h1CE0_0001}}, 1);
        release_req(1'b1, 1'b0);

        // second contention: round-robin hands it to I
`ifdef CACHELINE_ARB_RR_EN
        first_d = 1'b0;
`else
        first_d = 1'b1;
`endif
        @(negedge clk);
        i_read    = 1'b1;
        d_read    = 1'b1;
        i_address = 32'h0000_0300;
        d_address = 32'h0000_0400;
        if (first_d) begin
            push_exp(1'b1, 1'b0, 32'h0000_0400, 256'h0);
            push_exp(1'b0, 1'b0, 32'h0000_0300, 256'h0);
        end else begin
            push_exp(1'b0, 1'b0, 32'h0000_0300, 256'h0);
            push_exp(1'b1, 1'b0, 32'h0000_0400, 256'h0);
        end
        wait_grant(1);
        check_front();
        respond({8{32'hAB00_0002}}, 1);
        release_req(!first_d, first_d);
        wait_grant(1);
        check_front();
        respond({8{32'hAB00_0003}}, 2);
        release_req(1'b1, 1'b1);

        // address change mid-transaction must not reach pmem_address
        @(negedge clk);
        d_read    = 1'b1;
        d_address = 32'h1000_0000;
        push_exp(1'b1, 1'b0, 32'h1000_0000, 256'h0);
        wait_grant(1);
        check_front();
        @(negedge clk);
        #1;
        chk_addr("addr_change_c1", pmem_address, 32'h1000_0000);
        @(negedge clk);
        d_address = 32'hDEAD_0000;
        #1;
        chk_addr("addr_change_c2", pmem_address, 32'h1000_0000);
        respond({8{32'h5555_AAAA}}, 3);
        release_req(1'b1, 1'b1);

        // reset mid ARB_I aborts asynchronously with no resp
        @(negedge clk);
        i_read    = 1'b1;
        i_address = 32'h0000_0500;
        push_exp(1'b0, 1'b0, 32'h0000_0500, 256'h0);
        wait_grant(1);
        check_front();
        #2;
        rst        = 1'b1;
        pmem_resp  = 1'b1;
        pmem_rdata = {8{32'hBAD0_BAD0}};
        #1;
        chk_bit("abort_pmem_read", pmem_read, 1'b0);
        chk_bit("abort_i_resp", i_resp, 1'b0);
        chk_bit("abort_d_resp", d_resp, 1'b0);
        chk_addr("abort_address", pmem_address, 32'h0);
        sb.delete();
        @(negedge clk);
        rst       = 1'b0;
        pmem_resp = 1'b0;
        i_read    = 1'b0;
        #1;
        chk_bit("post_rst_idle", pmem_read | pmem_write, 1'b0);
        v = '{1'b1, 1'b0, 1'b0, 32'h0000_0527, 32'h0, 256'h0, {8{32'h7777_8888}},
              2, 1'b0, 1'b0, 32'h0000_0520};
        run_vec(v);

        // spurious pmem_resp while idle
        @(negedge clk);
        pmem_resp  = 1'b1;
        pmem_rdata = {256{1'b1}};
        #1;
        chk_bit("spurious_i_resp", i_resp, 1'b0);
        chk_bit("spurious_d_resp", d_resp, 1'b0);
        @(negedge clk);
        pmem_resp = 1'b0;
        #1;
        chk_bit("spurious_strobes", pmem_read | pmem_write, 1'b0);
        chk_bit("spurious_resp_after", i_resp | d_resp, 1'b0);
        chk_int("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
